// File: rtl/execute_stage_pipe.sv
// ============================================================================
// execute_stage_pipe
//   Execute stage of the integer pipeline: operand-B select, ALU, branch-target
//   adder and the EX/MEM output register, with a valid/ready handshake on both
//   sides and a flush input. Control bits from decode pass straight through.
//
//   Optional feature (macro EXEC_MULDIV_EN):
//     defined   - iterative MUL (shift-add) / DIVU / REMU (restoring) unit,
//                 one bit per cycle, with an IDLE/BUSY/DONE FSM.
//     undefined - codes 1010/1011/1100 complete in one cycle with result 0,
//                 busy is tied low.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush             kill the in-flight op and the output slot
//   in_valid/in_ready handshake from decode (accept = in_valid & in_ready)
//   pc, ex_imm, op1, op2, sa, rd_in, alu_src, alu_op   op fields
//   mem_r, mem_w, wb, reg_w, pc_src                    control pass-through
//   out_valid/out_ready handshake to the memory stage
//   branch_addr       pc + (ex_imm << 2)
//   alu_res, zero     result and result==0 flag
//   rd_out, *_out     registered copies of destination and control bits
//   busy              multi-cycle unit active (BUSY or DONE)
// ============================================================================
module execute_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SA_W       = $clog2(XLEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       ex_imm,
    input  logic [XLEN-1:0]       op1,
    input  logic [XLEN-1:0]       op2,
    input  logic [SA_W-1:0]       sa,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [1:0]            alu_src,
    input  logic [3:0]            alu_op,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic                  wb,
    input  logic                  reg_w,
    input  logic [1:0]            pc_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       branch_addr,
    output logic [XLEN-1:0]       alu_res,
    output logic                  zero,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  mem_r_out,
    output logic                  mem_w_out,
    output logic                  wb_out,
    output logic                  reg_w_out,
    output logic [1:0]            pc_src_out,
    output logic                  busy
);

    typedef struct packed {
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       reg_w;
        logic [1:0] pc_src;
    } ctrl_t;

    ctrl_t                  ctrl_in;
    logic [XLEN-1:0]        b;
    logic [SA_W-1:0]        shamt;
    logic [XLEN-1:0]        alu_comb;
    logic [XLEN-1:0]        branch_comb;
    logic                   slot_free;
    logic                   idle;
    logic                   accept;
    logic                   is_md;
    logic                   load_single;
    logic                   load_md;
    logic [XLEN-1:0]        md_res;
    logic [REG_ADDR_W-1:0]  p_rd;
    ctrl_t                  p_ctrl;
    logic [XLEN-1:0]        p_branch;

    assign ctrl_in     = '{mem_r: mem_r, mem_w: mem_w, wb: wb, reg_w: reg_w, pc_src: pc_src};
    assign branch_comb = pc + (ex_imm << 2);
    assign slot_free   = ~out_valid | out_ready;
    // rst gates in_ready so nothing is accepted while the stage is held in reset.
    assign in_ready    = rst & idle & ~flush & slot_free;
    assign accept      = in_valid & in_ready;
    assign load_single = accept & ~is_md;

    // Operand B select and single-cycle ALU.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        b        = op2;
        alu_comb = '0;
        case (alu_src)
            2'b01:   b = ex_imm;
            2'b10:   b = {{(XLEN-SA_W){1'b0}}, sa};
            default: b = op2;
        endcase
        shamt = b[SA_W-1:0];
        case (alu_op)
            4'b0000: alu_comb = op1 & b;
            4'b0001: alu_comb = op1 | b;
            4'b0010: alu_comb = op1 + b;
            4'b0011: alu_comb = op1 - b;
            4'b0100: alu_comb = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(b))};
            4'b0101: alu_comb = op1 << shamt;
            4'b0110: alu_comb = op1 >> shamt;
            4'b0111: alu_comb = $signed(op1) >>> shamt;
            4'b1000: alu_comb = op1 ^ b;
            4'b1001: alu_comb = ~(op1 | b);
            default: alu_comb = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_op_t;

    localparam logic [SA_W-1:0] CNT_MAX = SA_W'(XLEN - 1);

    state_t          state;
    md_op_t          md_op;
    logic [SA_W-1:0] count;
    logic [XLEN-1:0] acc;   // MUL: running product; DIV: partial remainder
    logic [XLEN-1:0] aux;   // MUL: shifted multiplicand; DIV: divisor
    logic [XLEN-1:0] q;     // MUL: remaining multiplier; DIV: dividend in / quotient out
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_next;

    // Restoring division step. Divisor 0 always subtracts, which yields
    // quotient all-ones and remainder = dividend without special casing.
    assign rem_shift = {acc, q[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, aux};
    assign rem_next  = rem_ge ? XLEN'(rem_shift - {1'b0, aux}) : rem_shift[XLEN-1:0];

    assign is_md   = alu_op inside {4'b1010, 4'b1011, 4'b1100};
    assign idle    = (state == IDLE);
    assign busy    = (state != IDLE);
    assign load_md = (state == DONE) & ~flush & slot_free;

    always_comb begin
        case (md_op)
            MD_DIVU: md_res = q;
            default: md_res = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the datapath holding registers are reset too so a reset mid-BUSY leaves no partial result behind.
            state    <= IDLE;
            md_op    <= MD_MUL;
            count    <= '0;
            acc      <= '0;
            aux      <= '0;
            q        <= '0;
            p_rd     <= '0;
            p_ctrl   <= '0;
            p_branch <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: if (accept && is_md) begin
                    state    <= BUSY;
                    count    <= CNT_MAX;
                    md_op    <= (alu_op == 4'b1010) ? MD_MUL :
                                (alu_op == 4'b1011) ? MD_DIVU : MD_REMU;
                    acc      <= '0;
                    aux      <= b;
                    q        <= op1;
                    p_rd     <= rd_in;
                    p_ctrl   <= ctrl_in;
                    p_branch <= branch_comb;
                end
                BUSY: begin
                    if (md_op == MD_MUL) begin
                        if (q[0]) acc <= acc + aux;
                        aux <= aux << 1;
                        q   <= q >> 1;
                    end else begin
                        acc <= rem_next;
                        q   <= {q[XLEN-2:0], rem_ge};
                    end
                    if (count == '0) state <= DONE;
                    else             count <= count - 1'b1;
                end
                DONE: if (slot_free) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign is_md    = 1'b0;
    assign idle     = 1'b1;
    assign busy     = 1'b0;
    assign load_md  = 1'b0;
    assign md_res   = '0;
    assign p_rd     = '0;
    assign p_ctrl   = '0;
    assign p_branch = '0;
`endif

    // EX/MEM output register. Flush only drops the valid bit; the stale data
    // is harmless because out_valid qualifies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            alu_res     <= '0;
            zero        <= 1'b0;
            branch_addr <= '0;
            rd_out      <= '0;
            {mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out} <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_single) begin
            out_valid   <= 1'b1;
            alu_res     <= alu_comb;
            zero        <= (alu_comb == '0);
            branch_addr <= branch_comb;
            rd_out      <= rd_in;
            {mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out} <= ctrl_in;
        end else if (load_md) begin
            out_valid   <= 1'b1;
            alu_res     <= md_res;
            zero        <= (md_res == '0);
            branch_addr <= p_branch;
            rd_out      <= p_rd;
            {mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out} <= p_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// ============================================================================
// tb_execute_stage_pipe
//   Directed testbench for execute_stage_pipe (XLEN=32). Each scenario task
//   drives its own stimulus and compares against hand-computed values.
//   Multi-cycle MUL/DIVU/REMU scenarios are built when EXEC_MULDIV_EN is
//   defined; otherwise those codes are checked as one-cycle zero results.
// ============================================================================
module tb_execute_stage_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc, ex_imm, op1, op2;
    logic [4:0]  sa;
    logic [4:0]  rd_in;
    logic [1:0]  alu_src;
    logic [3:0]  alu_op;
    logic        mem_r, mem_w, wb, reg_w;
    logic [1:0]  pc_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] branch_addr, alu_res;
    logic        zero;
    logic [4:0]  rd_out;
    logic        mem_r_out, mem_w_out, wb_out, reg_w_out;
    logic [1:0]  pc_src_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    execute_stage_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .ex_imm(ex_imm), .op1(op1), .op2(op2), .sa(sa), .rd_in(rd_in),
        .alu_src(alu_src), .alu_op(alu_op), .mem_r(mem_r), .mem_w(mem_w), .wb(wb),
        .reg_w(reg_w), .pc_src(pc_src), .out_valid(out_valid), .out_ready(out_ready),
        .branch_addr(branch_addr), .alu_res(alu_res), .zero(zero), .rd_out(rd_out),
        .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .wb_out(wb_out),
        .reg_w_out(reg_w_out), .pc_src_out(pc_src_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  src;
        logic [31:0] a;
        logic [31:0] bv;
        logic [31:0] imm;
        logic [31:0] pcv;
        logic [4:0]  sav;
        logic [31:0] exp;
        logic [31:0] exp_br;
    } vec_t;

    vec_t vecs [17];

    // Present one op at the falling edge, hold it across one rising edge.
    task automatic drive_op(input logic [3:0] op, input logic [1:0] src,
                            input logic [31:0] a, input logic [31:0] bv,
                            input logic [31:0] imm, input logic [31:0] pcv,
                            input logic [4:0] sav, input logic [4:0] rd,
                            input logic [5:0] ctrl, output logic was_ready);
        @(negedge clk);
        alu_op = op; alu_src = src; op1 = a; op2 = bv; ex_imm = imm; pc = pcv;
        sa = sav; rd_in = rd; {mem_r, mem_w, wb, reg_w, pc_src} = ctrl;
        in_valid = 1'b1;
        #1 was_ready = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (alu_res !== 32'h0) begin errors++; $display("FAIL reset_alu_res: got %h expected 0", alu_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b expected 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_alu;
        logic r;
        //               op       src    a             bv            imm           pc            sa     exp           br
        vecs[0]  = '{4'b0010, 2'b00, 32'h0,        32'h01111111, 32'h0,        32'h0,        5'd0,  32'h01111111, 32'h0};
        vecs[1]  = '{4'b0100, 2'b01, 32'hFFFFFFFF, 32'h0,        32'h4,        32'h8,        5'd0,  32'h1,        32'h18};
        vecs[2]  = '{4'b0011, 2'b00, 32'h5,        32'h5,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0};
        vecs[3]  = '{4'b0000, 2'b00, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,        5'd0,  32'hF000,     32'h0};
        vecs[4]  = '{4'b0001, 2'b00, 32'hF0F0,     32'h0F0F,     32'h0,        32'h0,        5'd0,  32'hFFFF,     32'h0};
        vecs[5]  = '{4'b0101, 2'b10, 32'h1,        32'h0,        32'h0,        32'h0,        5'd4,  32'h10,       32'h0};
        vecs[6]  = '{4'b0110, 2'b10, 32'h80000000, 32'h0,        32'h0,        32'h0,        5'd31, 32'h1,        32'h0};
        vecs[7]  = '{4'b0111, 2'b10, 32'h80000000, 32'h0,        32'h0,        32'h0,        5'd4,  32'hF8000000, 32'h0};
        vecs[8]  = '{4'b1000, 2'b00, 32'hFF,       32'h0F,       32'h0,        32'h0,        5'd0,  32'hF0,       32'h0};
        vecs[9]  = '{4'b1001, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'h0};
        vecs[10] = '{4'b0010, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0};
        vecs[11] = '{4'b0010, 2'b11, 32'h1,        32'h2,        32'h64,       32'h100,      5'd0,  32'h3,        32'h290};
        vecs[12] = '{4'b1111, 2'b00, 32'h5,        32'h5,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0};
        vecs[13] = '{4'b0011, 2'b00, 32'h0,        32'h1,        32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'h0};
        vecs[14] = '{4'b0100, 2'b00, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  32'h0,        32'h0};
        vecs[15] = '{4'b0101, 2'b00, 32'h3,        32'h21,       32'h0,        32'h0,        5'd0,  32'h6,        32'h0};
        vecs[16] = '{4'b0010, 2'b01, 32'hA,        32'h0,        32'hFFFFFFFE, 32'h20,       5'd0,  32'h8,        32'h18};
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic [5:0] ctrl;
            logic [4:0] rd;
            ctrl = 6'(i * 5 + 3);
            rd   = 5'(i + 1);
            drive_op(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].bv, vecs[i].imm,
                     vecs[i].pcv, vecs[i].sav, rd, ctrl, r);
            checks++; if (r !== 1'b1) begin errors++; $display("FAIL alu[%0d]_in_ready: got %b expected 1", i, r); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu[%0d]_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (alu_res !== vecs[i].exp) begin errors++; $display("FAIL alu[%0d]_res: got %h expected %h", i, alu_res, vecs[i].exp); end
            checks++; if (zero !== (vecs[i].exp == 32'h0)) begin errors++; $display("FAIL alu[%0d]_zero: got %b expected %b", i, zero, vecs[i].exp == 32'h0); end
            checks++; if (branch_addr !== vecs[i].exp_br) begin errors++; $display("FAIL alu[%0d]_branch: got %h expected %h", i, branch_addr, vecs[i].exp_br); end
            checks++; if (rd_out !== rd) begin errors++; $display("FAIL alu[%0d]_rd: got %0d expected %0d", i, rd_out, rd); end
            checks++; if ({mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out} !== ctrl) begin
                errors++; $display("FAIL alu[%0d]_ctrl: got %b expected %b", i,
                                   {mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out}, ctrl);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic r;
        logic [31:0] exp_res [3] = '{32'd3, 32'd7, 32'd11};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(4'b0010, 2'b00, 32'(2 * i + 1), 32'(2 * i + 2), 32'h0, 32'h0, 5'd0,
                     5'(10 + i), 6'h0, r);
            checks++; if (r !== 1'b1 || out_valid !== 1'b1 || alu_res !== exp_res[i] || rd_out !== 5'(10 + i)) begin
                errors++; $display("FAIL b2b[%0d]: got ready=%b valid=%b res=%h rd=%0d expected 1 1 %h %0d",
                                   i, r, out_valid, alu_res, rd_out, exp_res[i], 10 + i);
            end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic r;
        out_ready = 1'b0;
        drive_op(4'b0010, 2'b00, 32'h1, 32'h1, 32'h0, 32'h0, 5'd0, 5'd3, 6'h0, r);
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'h2) begin
            errors++; $display("FAIL bp_first: got valid=%b res=%h expected 1 2", out_valid, alu_res);
        end
        @(negedge clk);
        alu_op = 4'b0010; alu_src = 2'b00; op1 = 32'd10; op2 = 32'd20; rd_in = 5'd4;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", k, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || alu_res !== 32'h2 || rd_out !== 5'd3) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b res=%h rd=%0d expected 1 2 3", k, out_valid, alu_res, rd_out);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd30 || rd_out !== 5'd4) begin
            errors++; $display("FAIL bp_next: got valid=%b res=%h rd=%0d expected 1 1e 4", out_valid, alu_res, rd_out);
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush;
        logic r;
        out_ready = 1'b0;
        drive_op(4'b0010, 2'b00, 32'd7, 32'd8, 32'h0, 32'h0, 5'd0, 5'd5, 6'h0, r);
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd15) begin
            errors++; $display("FAIL flush_setup: got valid=%b res=%h expected 1 f", out_valid, alu_res);
        end
        @(negedge clk);
        out_ready = 1'b1;
        flush = 1'b1;
        alu_op = 4'b0010; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_wins: got %b expected 0", out_valid); end
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] bv,
                          output logic [31:0] res, output int n, output logic busy_ok);
        logic r;
        out_ready = 1'b1;
        drive_op(op, 2'b00, a, bv, 32'h0, 32'h0, 5'd0, 5'd7, 6'h0, r);
        n = 0;
        busy_ok = r;
        while (!out_valid && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        res = alu_res;
    endtask

    task automatic test_muldiv;
        logic [31:0] res;
        int          n;
        logic        ok;
        logic [3:0]  ops [6] = '{4'b1010, 4'b1011, 4'b1100, 4'b1011, 4'b1100, 4'b1010};
        logic [31:0] as  [6] = '{32'h10000, 32'd7, 32'd7, 32'd100, 32'd100, 32'hFFFFFFFF};
        logic [31:0] bs  [6] = '{32'h10001, 32'd0, 32'd0, 32'd7,   32'd7,   32'hFFFFFFFF};
        logic [31:0] ex  [6] = '{32'h10000, 32'hFFFFFFFF, 32'd7, 32'd14, 32'd2, 32'd1};
        for (int i = 0; i < 6; i++) begin
            run_md(ops[i], as[i], bs[i], res, n, ok);
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL md[%0d]_res: got %h expected %h", i, res, ex[i]); end
            checks++; if (n != 33) begin errors++; $display("FAIL md[%0d]_latency: got %0d expected 33", i, n); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL md[%0d]_busy: got %b expected 1", i, ok); end
        end
    endtask

    task automatic test_md_flush;
        logic r;
        int   seen;
        out_ready = 1'b1;
        drive_op(4'b1010, 2'b00, 32'd3, 32'd5, 32'h0, 32'h0, 5'd0, 5'd1, 6'h0, r);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mdflush_idle: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mdflush_ready: got %b expected 1", in_ready); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mdflush_discard: got %0d valid cycles expected 0", seen); end
    endtask
`else
    task automatic test_muldiv_disabled;
        logic r;
        logic [3:0] ops [3] = '{4'b1010, 4'b1011, 4'b1100};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], 2'b00, 32'd6, 32'd7, 32'h0, 32'h0, 5'd0, 5'd9, 6'h0, r);
            checks++; if (r !== 1'b1 || out_valid !== 1'b1 || alu_res !== 32'h0 || zero !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL mddis[%0d]: got ready=%b valid=%b res=%h zero=%b busy=%b expected 1 1 0 1 0",
                                   i, r, out_valid, alu_res, zero, busy);
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic r;
`ifdef EXEC_MULDIV_EN
        out_ready = 1'b1;
        drive_op(4'b1010, 2'b00, 32'd9, 32'd9, 32'h4, 32'h40, 5'd0, 5'd6, 6'h3F, r);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
`else
        out_ready = 1'b0;
        drive_op(4'b0010, 2'b00, 32'h55, 32'h0, 32'h4, 32'h40, 5'd0, 5'd6, 6'h3F, r);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_before: got %b expected 1", out_valid); end
`endif
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || alu_res !== 32'h0 || branch_addr !== 32'h0 || rd_out !== 5'd0 ||
                      {mem_r_out, mem_w_out, wb_out, reg_w_out, pc_src_out} !== 6'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got valid=%b res=%h br=%h rd=%0d busy=%b ready=%b expected all 0",
                               out_valid, alu_res, branch_addr, rd_out, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive_op(4'b0010, 2'b00, 32'd2, 32'd3, 32'h0, 32'h0, 5'd0, 5'd2, 6'h0, r);
        checks++; if (r !== 1'b1 || out_valid !== 1'b1 || alu_res !== 32'd5 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_after_add: got ready=%b valid=%b res=%h busy=%b expected 1 1 5 0",
                               r, out_valid, alu_res, busy);
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; ex_imm = '0; op1 = '0; op2 = '0; sa = '0; rd_in = '0;
        alu_src = '0; alu_op = '0; mem_r = 1'b0; mem_w = 1'b0; wb = 1'b0; reg_w = 1'b0; pc_src = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_backpressure();
        test_flush();
`ifdef EXEC_MULDIV_EN
        test_muldiv();
        test_md_flush();
`else
        test_muldiv_disabled();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
